demux1_8_deser: RTL
===================

# demux1_8_deser

Serial-to-parallel 1:WIDTH demultiplexing receiver: routes successive valid serial bits into output lanes 0..WIDTH-1 under an internal lane-select counter and presents the assembled word with a one-cycle valid pulse. It is the receiving end of the mux-based serializer path (lane select 0 first, incrementing), recovering the parallel word that the 8:1 mux scanned out.

## Interface
- WIDTH, 8, number of lanes / word width; power of two, ≥2
- SEL_W, $clog2(WIDTH), lane-index width (derived localparam, not overridable)

- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- clr  input  1  synchronous frame abort; discards partial word
- din  input  1  serial data bit
- din_valid  input  1  din is sampled this cycle
- y  output  WIDTH  last completed word, lane k = k-th accepted bit of frame
- y_valid  output  1  one-cycle pulse, y updated this cycle
- sel  output  SEL_W  lane index the next accepted data bit goes to
- busy  output  1  partial frame held (state ≠ IDLE)
- parity_err  output  1  parity mismatch flag, qualified by y_valid (only with DEMUX_PARITY_EN; tied 0 otherwise)

## Operation
- States: IDLE (sel=0, nothing staged), COLLECT (1..WIDTH-1 bits staged), PARITY (macro only; all data bits staged, awaiting parity bit).
- IDLE + din_valid: stage[0]←din, sel←1, → COLLECT.
- COLLECT + din_valid, sel<WIDTH-1: stage[sel]←din, sel←sel+1.
- COLLECT + din_valid, sel=WIDTH-1: without macro, y←{din, stage[WIDTH-2:0]}, y_valid←1, sel←0, → IDLE. With macro, stage[WIDTH-1]←din, sel←0, → PARITY.
- PARITY + din_valid: y←stage, y_valid←1, parity_err←(^stage)^din (even parity; error when 1), → IDLE.
- din_valid low: no state change; gaps of any length are allowed between bits.
- clr high: → IDLE, sel←0, staged bits discarded; y, parity_err unchanged; y_valid←0. clr wins over a simultaneous din_valid (bit dropped, including the final bit).
- y holds its value between frames; never partially updated.
- sel wraps WIDTH-1→0 with no overflow flag.

## Timing
- Reset (async assert, sync-safe deassert by system): y=0, y_valid=0, sel=0, busy=0, parity_err=0, state IDLE.
- Reset mid-frame: all staged bits lost; first bit after release is lane 0.
- Latency: y/y_valid registered, asserted the cycle after the last bit (data bit, or parity bit with macro) is sampled.
- Throughput: continuous din_valid yields y_valid every WIDTH cycles (WIDTH+1 with macro); first bit of next frame may be sampled in the same cycle y_valid is high.
- busy and sel are registered state, updated the cycle after each accepted bit.
- No backpressure; the consumer must capture y on y_valid.

## Configuration
- DEMUX_PARITY_EN defined: frame = WIDTH data bits + 1 even-parity bit; PARITY state present; parity_err driven, updated only with y_valid, held otherwise.
- Undefined: frame = WIDTH data bits; no PARITY state; parity_err constant 0.

## Structure
- Shared package demux_pkg: state enum (IDLE, COLLECT, PARITY), default WIDTH constant.
- One natural sub-module: demux_sel_ctr, SEL_W-bit lane counter with increment, synchronous clear, async reset, and terminal-count output (sel=WIDTH-1).
- Staging register, FSM, and output registers stay in the top.

## Test plan
- Reset: hold rst_n low with din toggling → y=0, y_valid=0, sel=0, busy=0, parity_err=0.
- Frame 0x44 LSB-first, continuous valid → after 8th bit, y=8'h44, single y_valid pulse, sel back to 0, busy low.
- Back-to-back 0x44 then 0xC4 → y_valid pulses exactly 8 cycles apart, y=8'h44 then 8'hC4; y holds 8'hC4 afterward.
- 0xC4 with random 0–5 cycle din_valid gaps → y=8'hC4, one pulse; sel stalls during gaps.
- 3 bits accepted, then clr together with a valid bit, then 0x44 → y=8'h44; y unchanged at clr; no spurious pulse. Repeat with rst_n pulse mid-frame → same result.
- Macro on: 0x44 + parity 0 → y=8'h44, parity_err=0; 0xC4 + parity 0 → y=8'hC4, parity_err=1.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and defaults for the 1:WIDTH serial demultiplexing receiver.
// Optional even-parity framing is enabled with DEMUX_PARITY_EN.
package demux_pkg;

    localparam int DEMUX_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } demux_state_e;

endpackage

// File: rtl/demux1_8_deser_if.sv
// Serial input and parallel-word output bundle of the demux receiver.
// The receiver takes the slave view; the upstream/consumer side takes master.
interface demux1_8_deser_if #(
    parameter int WIDTH = demux_pkg::DEMUX_WIDTH
);
    localparam int SEL_W = $clog2(WIDTH);

    logic             clr;
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [SEL_W-1:0] sel;
    logic             busy;
    logic             parity_err;

    modport master (
        output clr, din, din_valid,
        input  y, y_valid, sel, busy, parity_err
    );

    modport slave (
        input  clr, din, din_valid,
        output y, y_valid, sel, busy, parity_err
    );

endinterface

// File: rtl/demux_sel_ctr.sv
// Lane-select counter: increments once per accepted data bit, wraps at WIDTH-1,
// synchronous clear for frame abort, terminal count flags the last lane.
module demux_sel_ctr #(
    parameter  int WIDTH = 8,
    localparam int SEL_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [SEL_W-1:0] sel,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= '0;
        end else if (clr) begin
            sel <= '0;
        end else if (inc) begin
            sel <= sel + 1'b1;
        end
    end

    assign tc = (sel == SEL_W'(WIDTH - 1));

endmodule

// File: rtl/demux1_8_deser.sv
// 1:WIDTH serial-to-parallel receiver; lane 0 takes the first bit of a frame.
// Define DEMUX_PARITY_EN to append and check an even-parity bit per frame.
//
// state   | meaning
// IDLE    | sel=0, nothing staged
// COLLECT | 1..WIDTH-1 data bits staged
// PARITY  | all data bits staged, waiting for the parity bit (DEMUX_PARITY_EN)
module demux1_8_deser
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input logic              clk,
    input logic              rst_n,
    demux1_8_deser_if.slave  bus
);

    localparam int SEL_W = $clog2(WIDTH);

    demux_state_e     state_q, state_d;
    logic [WIDTH-1:0] stage_q, stage_d;
    logic [WIDTH-1:0] y_q;
    logic             y_valid_q;
    logic             load_y;
    logic             ctr_inc;
    logic [SEL_W-1:0] sel;
    logic             sel_tc;

    demux_sel_ctr #(.WIDTH(WIDTH)) u_sel_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clr),
        .inc   (ctr_inc),
        .sel   (sel),
        .tc    (sel_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // clr outranks din_valid, so an aborted frame never completes on its last bit
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        load_y  = 1'b0;
        ctr_inc = 1'b0;
        if (bus.clr) begin
            state_d = IDLE;
        end else if (bus.din_valid) begin
            case (state_q)
                IDLE: begin
                    stage_d[sel] = bus.din;
                    ctr_inc      = 1'b1;
                    state_d      = COLLECT;
                end
                COLLECT: begin
                    stage_d[sel] = bus.din;
                    ctr_inc      = 1'b1;
                    if (sel_tc) begin
`ifdef DEMUX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
                        load_y  = 1'b1;
`endif
                    end
                end
`ifdef DEMUX_PARITY_EN
                PARITY: begin
                    load_y  = 1'b1;
                    state_d = IDLE;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q   <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            y_valid_q <= load_y;
            if (load_y) begin
                y_q <= stage_d;
            end
        end
    end

`ifdef DEMUX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_q <= 1'b0;
        end else if (load_y) begin
            parity_err_q <= (^stage_q) ^ bus.din;
        end
    end

    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.sel     = sel;
    assign bus.busy    = (state_q != IDLE);

endmodule
